// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//
// Run-control block for the pipelined MIPS CPU simulation and board harness.
// It holds the CPU core in reset for RESET_CYCLES cycles, releases it, then
// counts RUN cycles and retired instructions. The run ends on a retired
// instruction at HALT_PC, an external halt request, or a cycle-limit timeout.
// A restart pulse aborts the current run (or re-arms a finished one) and
// starts a fresh reset hold.
//
// Parameters:
//   RESET_CYCLES  cycles the core reset is held low (>= 1)
//   CNT_W         width of cycle_cnt / instr_cnt
//   MAX_CYCLES    RUN-cycle limit, 0 disables the timeout
//   PC_W          retire PC width
//   HALT_PC       retiring at this PC ends the run normally
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, beats every other input
//   restart    in   single-cycle pulse: abort / re-arm a run
//   retire     in   writeback retired one instruction this cycle
//   retire_pc  in   PC of the retiring instruction (valid with retire)
//   halt_req   in   external halt request, level-sampled
//   cpu_rst_n  out  active-low core reset, high only in RUN
//   running    out  state is RUN
//   done       out  state is DONE (normal halt)
//   timeout    out  state is TIMEOUT
//   cycle_cnt  out  RUN cycles elapsed (saturating)
//   instr_cnt  out  instructions retired during RUN (saturating)
//   state_dbg  out  current FSM state, for checkers and debug
//
// All outputs come straight from flops. The flag and reset flops are loaded
// from the decoded next state so they change on the same edge as the state.
// -----------------------------------------------------------------------------
module cpu_run_controller #(
   parameter int unsigned     RESET_CYCLES = 5,
   parameter int unsigned     CNT_W        = 32,
   parameter int unsigned     MAX_CYCLES   = 100000,
   parameter int unsigned     PC_W         = 32,
   parameter logic [PC_W-1:0] HALT_PC      = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             retire,
   input  logic [PC_W-1:0]  retire_pc,
   input  logic             halt_req,
   output logic             cpu_rst_n,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [1:0]       state_dbg
);

   // FSM encoding
   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic [1:0] S_TIMEOUT = 2'd3;

   // Hold counter only ever needs to reach RESET_CYCLES-1.
   localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

   // Timeout fires in the cycle whose incoming cycle_cnt equals MAX_CYCLES-1,
   // so the counted total lands exactly on MAX_CYCLES. Compared at 64 bits so
   // a narrow counter can never alias onto the limit.
   localparam bit          TIMEOUT_EN = (MAX_CYCLES != 0);
   localparam logic [63:0] MAX_LAST   = TIMEOUT_EN ? (64'(MAX_CYCLES) - 64'd1) : 64'd0;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]        state_q,     state_d;
   logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              running_q,   running_d;
   logic              done_q,      done_d;
   logic              timeout_q,   timeout_d;

   logic              halt_hit;
   logic              timeout_hit;
   logic [CNT_W-1:0]  cycle_cnt_inc;
   logic [CNT_W-1:0]  instr_cnt_inc;

   // Run-end conditions; only acted on while in RUN.
   assign halt_hit    = (retire && (retire_pc == HALT_PC)) || halt_req;
   assign timeout_hit = TIMEOUT_EN && (64'(cycle_cnt_q) == MAX_LAST);

   // Saturating increments: stick at all-ones instead of wrapping.
   assign cycle_cnt_inc = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
   assign instr_cnt_inc = (instr_cnt_q == CNT_MAX) ? instr_cnt_q : instr_cnt_q + 1'b1;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;

      case (state_q)
         S_HOLD: begin
            // retire / halt_req are meaningless while the core is in reset.
            if (restart) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         S_RUN: begin
            if (restart) begin
               state_d     = S_HOLD;
               hold_cnt_d  = '0;
               cycle_cnt_d = '0;
               instr_cnt_d = '0;
            end else begin
               // The cycle that ends the run is still counted, as is a
               // halting instruction retiring in it.
               cycle_cnt_d = cycle_cnt_inc;
               if (retire) begin
                  instr_cnt_d = instr_cnt_inc;
               end
               // Halt wins over a coincident timeout.
               if (halt_hit) begin
                  state_d = S_DONE;
               end else if (timeout_hit) begin
                  state_d = S_TIMEOUT;
               end
            end
         end

         S_DONE, S_TIMEOUT: begin
            // Results stay frozen for the harness until re-armed.
            if (restart) begin
               state_d     = S_HOLD;
               hold_cnt_d  = '0;
               cycle_cnt_d = '0;
               instr_cnt_d = '0;
            end
         end

         default: begin
            state_d     = S_HOLD;
            hold_cnt_d  = '0;
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
         end
      endcase

      // Core runs only in RUN; DONE/TIMEOUT put it back into reset to freeze it.
      cpu_rst_n_d = (state_d == S_RUN);
      running_d   = (state_d == S_RUN);
      done_d      = (state_d == S_DONE);
      timeout_d   = (state_d == S_TIMEOUT);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HOLD;
         hold_cnt_q  <= '0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
         cpu_rst_n_q <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         running_q   <= running_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign cpu_rst_n = cpu_rst_n_q;
   assign running   = running_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
   assign state_dbg = state_q;

endmodule
